// File: rtl/mux_arb_pipe_pkg.sv
// Shared definitions for the pipelined N-way arbitrating multiplexer.
package mux_arb_pipe_pkg;

    // Select-mode encodings for the mode input
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Round-robin pointer advance: one past the granted channel, wrapping at n
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mux_arb_pipe_rr_pick.sv
// Round-robin picker: first requester at or after ptr, wrapping N-1 -> 0.
// Rotates the request vector so ptr lands at bit 0, priority-encodes, then
// adds ptr back (mod N). Works for any N >= 2, not only powers of two.
module rr_pick #(
    parameter int N    = 8,
    parameter int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] gnt_idx,
    output logic            gnt_any
);

    logic [N-1:0]    w_rot;
    logic [SELW-1:0] w_off;
    logic [SELW:0]   w_sum;

    // Rotate, lowest-set-bit priority, unrotate
    always_comb begin
        w_rot = N'({req, req} >> ptr);
        w_off = '0;
        for (int unsigned i = N; i > 0; i--) begin
            if (w_rot[i-1]) w_off = SELW'(i - 1);
        end
        w_sum = {1'b0, ptr} + {1'b0, w_off};
        if (w_sum >= (SELW+1)'(N)) w_sum = w_sum - (SELW+1)'(N);
        gnt_idx = w_sum[SELW-1:0];
        gnt_any = |req;
    end

endmodule

// File: rtl/mux_arb_pipe.sv
// N-way W-bit multiplexer with valid/ready handshake, fixed or round-robin
// select, and a single registered output stage (latency 1, full throughput).
module mux_arb_pipe
    import mux_arb_pipe_pkg::*;
#(
    parameter int N    = 8,
    parameter int W    = 8,
    parameter int SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    output logic [W-1:0]    out_data,
    output logic [SELW-1:0] out_src,
    output logic            out_valid,
    input  logic            out_ready
);

    logic [W-1:0]    r_out_data;
    logic [SELW-1:0] r_out_src;
    logic            r_out_valid;
    logic [SELW-1:0] r_rr_ptr;

    logic [SELW-1:0] w_rr_idx;
    logic            w_rr_any;
    logic            w_fixed_any;
    logic [SELW-1:0] w_gnt_idx;
    logic            w_gnt_any;
    logic            w_accept;
    logic [W-1:0]    w_gnt_data;
    logic [N-1:0]    w_in_ready;

    rr_pick #(.N(N), .SELW(SELW)) u_rr_pick (
        .req     (in_valid),
        .ptr     (r_rr_ptr),
        .gnt_idx (w_rr_idx),
        .gnt_any (w_rr_any)
    );

    // Grant select, data mux and in_ready decode
    always_comb begin
        w_accept    = !r_out_valid || out_ready;
        // Loop compare keeps sel >= N from ever matching a channel
        w_fixed_any = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (sel == SELW'(i) && in_valid[i]) w_fixed_any = 1'b1;
        end
        if (mode == MODE_RR) begin
            w_gnt_idx = w_rr_idx;
            w_gnt_any = w_rr_any;
        end else begin
            w_gnt_idx = sel;
            w_gnt_any = w_fixed_any;
        end
        w_gnt_data = '0;
        w_in_ready = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (w_gnt_idx == SELW'(i)) begin
                w_gnt_data    = in_data[i*W +: W];
                w_in_ready[i] = rst_n && w_accept && w_gnt_any;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign out_valid = r_out_valid;

    // Output register and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_out_valid <= 1'b0;
            r_rr_ptr    <= '0;
        end else if (w_accept) begin
            if (w_gnt_any) begin
                r_out_data  <= w_gnt_data;
                r_out_src   <= w_gnt_idx;
                r_out_valid <= 1'b1;
                if (mode == MODE_RR) r_rr_ptr <= SELW'(wrap_inc(32'(w_gnt_idx), N));
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule
